// File: rtl/lfsr_noise_gen.sv
// Galois LFSR noise source with a runtime step-rate divider, seed loading
// (an all-zero seed is replaced by SEED) and a sequence-wrap strobe.
module lfsr_noise_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h1C,
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
    parameter int               DIV_W = 8
) (
    input  logic             clk,
    input  logic             I_RSTn,
    input  logic             audio_clk_en,
    input  logic             run,
    input  logic [DIV_W-1:0] rate,
    input  logic             load,
    input  logic [WIDTH-1:0] load_seed,
    output logic [WIDTH-1:0] lfsr_q,
    output logic             noise_bit,
    output logic             step_stb,
    output logic             wrap_stb,
    output logic             zero_fix
);

    // Bit 0 always takes the feedback bit, so TAPS[0] plays no part.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb        = s[WIDTH-1];
        lfsr_step = {s[WIDTH-2:0], fb} ^ ({WIDTH{fb}} & {TAPS[WIDTH-1:1], 1'b0});
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] seed_val;
    logic             seed_zero;
    logic             qen;
    logic             shift;

    assign qen       = audio_clk_en & run;
    assign shift     = qen && (div_cnt == '0);
    assign next_q    = lfsr_step(lfsr_q);
    assign seed_zero = (load_seed == '0);
    assign seed_val  = seed_zero ? SEED : load_seed;
    assign noise_bit = lfsr_q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            lfsr_q   <= SEED;
            seed_reg <= SEED;
            div_cnt  <= '0;
            step_stb <= 1'b0;
            wrap_stb <= 1'b0;
            zero_fix <= 1'b0;
        end else begin
            step_stb <= 1'b0;
            wrap_stb <= 1'b0;
            zero_fix <= 1'b0;
            if (load) begin
                // A load overrides any shift requested in the same cycle.
                lfsr_q   <= seed_val;
                seed_reg <= seed_val;
                div_cnt  <= rate;
                zero_fix <= seed_zero;
            end else if (qen) begin
                if (shift) begin
                    lfsr_q   <= next_q;
                    div_cnt  <= rate;
                    step_stb <= 1'b1;
                    wrap_stb <= (next_q == seed_reg);
                end else begin
                    div_cnt <= div_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Bench for lfsr_noise_gen: polynomial-arithmetic reference model checked every
// cycle, directed scenarios with literal expectations, and a 16-bit period run.
module tb_lfsr_noise_gen;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       run = 1'b1;
    logic [7:0] rate = 8'd0;
    logic       load = 1'b0;
    logic [7:0] ld = 8'd0;
    logic [7:0] q;
    logic       noise, step, wrap, zf;

    logic        rst16n = 1'b0;
    logic        en16 = 1'b0;
    logic        run16 = 1'b1;
    logic [7:0]  rate16 = 8'd0;
    logic        load16 = 1'b0;
    logic [15:0] ld16 = 16'd0;
    logic [15:0] q16;
    logic        noise16, step16, wrap16, zf16;
    logic        done16 = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lfsr_noise_gen dut (
        .clk(clk), .I_RSTn(rstn), .audio_clk_en(en), .run(run), .rate(rate),
        .load(load), .load_seed(ld), .lfsr_q(q), .noise_bit(noise),
        .step_stb(step), .wrap_stb(wrap), .zero_fix(zf)
    );

    lfsr_noise_gen #(.WIDTH(16), .TAPS(16'h002D), .SEED(16'hFFFF), .DIV_W(8)) dut16 (
        .clk(clk), .I_RSTn(rst16n), .audio_clk_en(en16), .run(run16), .rate(rate16),
        .load(load16), .load_seed(ld16), .lfsr_q(q16), .noise_bit(noise16),
        .step_stb(step16), .wrap_stb(wrap16), .zero_fix(zf16)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next state = state * x mod (x^8 + x^4 + x^3 + x^2 + 1).
    function automatic logic [7:0] mulx(input logic [7:0] s);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t = t ^ 9'h11D;
        return t[7:0];
    endfunction

    logic [7:0] m_q, m_seed;
    int         m_wait;
    logic       m_step, m_wrap, m_zf;
    logic       m_valid = 1'b0;

    always @(posedge clk) begin
        m_step = 1'b0;
        m_wrap = 1'b0;
        m_zf   = 1'b0;
        if (!rstn) begin
            m_q = 8'hFF; m_seed = 8'hFF; m_wait = 0; m_valid = 1'b1;
        end else if (load) begin
            m_q    = (ld == 8'h00) ? 8'hFF : ld;
            m_seed = m_q;
            m_wait = int'(rate);
            m_zf   = (ld == 8'h00);
        end else if (en && run) begin
            if (m_wait == 0) begin
                m_q    = mulx(m_q);
                m_wait = int'(rate);
                m_step = 1'b1;
                m_wrap = (m_q == m_seed);
            end else begin
                m_wait--;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_q", q, m_q);
            check("model_noise", noise, m_q[7]);
            check("model_step", step, m_step);
            check("model_wrap", wrap, m_wrap);
            check("model_zero_fix", zf, m_zf);
        end
    end

    task automatic pulse(output logic stb);
        @(negedge clk) en = 1'b1;
        @(negedge clk) stb = step;
        en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rstn = 1'b0;
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic free_run(input int n, output int steps, output int wraps,
                            output int wrap_at);
        steps = 0; wraps = 0; wrap_at = -1;
        @(negedge clk) en = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (step) steps++;
            if (wrap) begin wraps++; wrap_at = steps; end
            if (i == n - 1) en = 1'b0;
        end
    endtask

    // 16-bit instance: full period of x^16+x^5+x^3+x^2+1.
    initial begin
        int n, zeros;
        bit wrapped;
        n = 0; zeros = 0; wrapped = 0;
        en16 = 1'b1;
        repeat (2) @(negedge clk);
        check("w16_reset_q", q16, 16'hFFFF);
        rst16n = 1'b1;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (step16) n++;
            if (n == 1 && step16) check("w16_first_step", q16, 16'hFFD3);
            if (q16 == 16'h0000) zeros++;
            if (wrap16) begin wrapped = 1; break; end
        end
        en16 = 1'b0;
        check("w16_wrapped", wrapped, 1);
        check("w16_period", n, 65535);
        check("w16_wrap_q", q16, 16'hFFFF);
        check("w16_zero_states", zeros, 0);
        done16 = 1'b1;
    end

    initial begin
        logic        s;
        logic [11:0] mask;
        logic [7:0]  saved;
        logic [7:0]  states [255];
        int steps, wraps, wrap_at, dups, zeros;

        repeat (2) @(negedge clk);
        check("reset_q", q, 8'hFF);
        check("reset_noise", noise, 1);
        check("reset_step", step, 0);
        check("reset_wrap", wrap, 0);
        check("reset_zero_fix", zf, 0);
        rstn = 1'b1;

        pulse(s);
        check("first_step_stb", s, 1);
        check("first_q", q, 8'hE3);
        check("first_noise", noise, 1);
        @(negedge clk);
        check("step_stb_one_cycle", step, 0);
        pulse(s);
        check("second_q", q, 8'hDB);
        check("second_noise", noise, 1);

        rate = 8'd3;
        for (int i = 0; i < 12; i++) begin
            pulse(s);
            mask[i] = s;
        end
        check("rate3_shift_pattern", mask, 12'h111);

        pulse(s);
        pulse(s);
        saved = q;
        @(negedge clk) begin run = 1'b0; en = 1'b1; end
        steps = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (step) steps++;
        end
        en = 1'b0; run = 1'b1;
        check("frozen_steps", steps, 0);
        check("frozen_q", q, saved);
        for (int i = 0; i < 3; i++) begin
            pulse(s);
            mask[i] = s;
        end
        check("resume_count", mask[2:0], 3'b100);

        rate = 8'd0;
        do_reset();
        steps = 0; wraps = 0; wrap_at = -1;
        @(negedge clk) en = 1'b1;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            states[i] = q;
            if (step) steps++;
            if (wrap) begin wraps++; wrap_at = steps; end
            if (i == 254) en = 1'b0;
        end
        check("free_steps", steps, 255);
        check("free_wraps", wraps, 1);
        check("free_wrap_at", wrap_at, 255);
        check("free_wrap_q", q, 8'hFF);
        dups = 0; zeros = 0;
        for (int i = 0; i < 255; i++) begin
            if (states[i] == 8'h00) zeros++;
            for (int j = i + 1; j < 255; j++)
                if (states[i] == states[j]) dups++;
        end
        check("free_duplicates", dups, 0);
        check("free_zero_states", zeros, 0);

        @(negedge clk) begin load = 1'b1; ld = 8'h00; end
        @(negedge clk) load = 1'b0;
        check("zero_load_q", q, 8'hFF);
        check("zero_load_fix", zf, 1);
        @(negedge clk);
        check("zero_fix_one_cycle", zf, 0);

        @(negedge clk) begin load = 1'b1; ld = 8'h5A; end
        @(negedge clk) load = 1'b0;
        check("load5a_q", q, 8'h5A);
        check("load5a_fix", zf, 0);
        check("load5a_step", step, 0);
        free_run(255, steps, wraps, wrap_at);
        check("seed5a_wraps", wraps, 1);
        check("seed5a_wrap_at", wrap_at, 255);
        check("seed5a_wrap_q", q, 8'h5A);

        @(negedge clk) begin load = 1'b1; ld = 8'h01; en = 1'b1; end
        @(negedge clk) begin load = 1'b0; en = 1'b0; end
        check("load_vs_shift_q", q, 8'h01);
        check("load_vs_shift_step", step, 0);
        @(negedge clk);
        check("load_vs_shift_later", q, 8'h01);

        pulse(s);
        pulse(s);
        @(negedge clk) begin rstn = 1'b0; en = 1'b1; load = 1'b1; ld = 8'h33; end
        @(negedge clk) begin rstn = 1'b1; en = 1'b0; load = 1'b0; end
        check("midreset_q", q, 8'hFF);
        check("midreset_step", step, 0);
        check("midreset_wrap", wrap, 0);
        check("midreset_zero_fix", zf, 0);
        pulse(s);
        check("after_reset_q", q, 8'hE3);

        wait (done16);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
